bcd_to_binary_seq: RTL and testbench

//   Sequential packed-BCD to unsigned binary converter: the inverse of the 8-bit

---
 rtl/bcd_to_binary_seq.sv | 135 +++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_binary_seq
//  Purpose  : Sequential packed-BCD to unsigned binary converter. Consumes one
//             BCD digit per clock, most significant digit first, using
//             acc <= acc*10 + digit. Uses a start/busy/done handshake.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             start_i    - conversion request, sampled only while idle
//             bcd_in_i   - packed BCD word, top nibble = most significant digit
//             busy_o     - high while digits are being consumed
//             done_o     - one-cycle pulse, bin_out_o/error_o freshly valid
//             bin_out_o  - binary result, held until the next done pulse
//             error_o    - a captured digit was above 9, held with bin_out_o
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_binary_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   bcd_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [BIN_W-1:0]      bin_out_o,
    output logic                  error_o
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    logic [0:0]          state_q,  state_d;
    logic [4*DIGITS-1:0] shreg_q,  shreg_d;
    logic [BIN_W-1:0]    acc_q,    acc_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                err_q,    err_d;
    logic [BIN_W-1:0]    bin_q,    bin_d;
    logic                errout_q, errout_d;
    logic                done_q,   done_d;

    logic [3:0]          w_digit;
    logic [BIN_W-1:0]    w_acc_mac;
    logic                w_digit_bad;
    logic                w_last;

    // Multiply-by-ten as two shifts and an add; wraps modulo 2**BIN_W.
    assign w_digit     = shreg_q[4*DIGITS-1 -: 4];
    assign w_acc_mac   = (acc_q << 3) + (acc_q << 1) + BIN_W'(w_digit);
    assign w_digit_bad = (w_digit > 4'd9);
    assign w_last      = (cnt_q == CNT_W'(DIGITS - 1));

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            bin_q    <= '0;
            errout_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            bin_q    <= bin_d;
            errout_q <= errout_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        bin_d    = bin_q;
        errout_d = errout_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CONV;
                    shreg_d = bcd_in_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_CONV: begin
                acc_d   = w_acc_mac;
                shreg_d = shreg_q << 4;
                err_d   = err_q | w_digit_bad;
                cnt_d   = cnt_q + CNT_W'(1);
                if (w_last) begin
                    // Publish the final digit's contribution directly so the
                    // result appears on the same edge as done.
                    state_d  = ST_IDLE;
                    bin_d    = w_acc_mac;
                    errout_d = err_q | w_digit_bad;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o    = (state_q == ST_CONV);
        done_o    = done_q;
        bin_out_o = bin_q;
        error_o   = errout_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_to_binary_seq
//  Purpose  : Directed self-checking bench for bcd_to_binary_seq
//             (DIGITS=3, BIN_W=10).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd;
    logic        busy;
    logic        done;
    logic [9:0]  bin;
    logic        err;

    int n_assert;
    int n_fail;

    bcd_to_binary_seq #(
        .DIGITS (3),
        .BIN_W  (10)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .bcd_in_i  (bcd),
        .busy_o    (busy),
        .done_o    (done),
        .bin_out_o (bin),
        .error_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: nibble-by-nibble accumulate, wrapped to 10 bits.
    function automatic logic [9:0] ref_bin(input logic [11:0] w);
        int acc;
        acc = 0;
        for (int i = 2; i >= 0; i--) acc = acc * 10 + int'(w[4*i +: 4]);
        return 10'(acc % 1024);
    endfunction

    function automatic logic ref_err(input logic [11:0] w);
        return (w[11:8] > 4'd9) || (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
    endfunction

    // Issue a one-cycle start, then verify busy, latency, result and done width.
    task automatic convert(input string tag, input logic [11:0] w,
                           input logic [9:0] eb, input logic ee);
        int lat;
        @(negedge clk);
        start = 1'b1;
        bcd   = w;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_bin"}, 32'(bin), 32'(eb));
        check({tag, "_err"}, 32'(err), 32'(ee));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int gap;
        int v;
        logic [11:0] w;
        logic        saw_done;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bcd      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bin",  32'(bin),  32'd0);
        check("rst_err",  32'(err),  32'd0);
        rst_n = 1'b1;

        // Basic conversion and boundaries
        convert("w255", 12'h255, 10'd255, 1'b0);
        convert("w000", 12'h000, 10'd0,   1'b0);
        convert("w999", 12'h999, 10'd999, 1'b0);
        convert("w001", 12'h001, 10'd1,   1'b0);
        convert("w100", 12'h100, 10'd100, 1'b0);

        // Invalid digits, then a valid word clears the flag
        convert("w1A5", 12'h1A5, 10'd205, 1'b1);
        convert("wFFF", 12'hFFF, 10'd641, 1'b1);
        convert("w042", 12'h042, 10'd42,  1'b0);

        // start and bcd_in wiggled while busy have no effect
        @(negedge clk);
        start = 1'b1;
        bcd   = 12'h321;
        @(negedge clk);
        start = 1'b0;
        bcd   = 12'h999;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("ign_done", 32'(done), 32'd1);
        check("ign_bin",  32'(bin),  32'd321);
        @(negedge clk);
        check("ign_idle", 32'(busy), 32'd0);

        // start held high: back-to-back words, new capture in done cycle
        @(negedge clk);
        bcd   = 12'h123;
        start = 1'b1;
        lat = 0;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("hold_first_done", 32'(done), 32'd1);
        check("hold_first_bin",  32'(bin),  32'd123);
        bcd = 12'h456;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (!done) check("hold_bin_kept", 32'(bin), 32'd123);
        end while (!done && gap < 12);
        check("hold_gap", 32'(gap), 32'd4);
        check("hold_second_bin", 32'(bin), 32'd456);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during the second conversion cycle aborts the word
        @(negedge clk);
        start = 1'b1;
        bcd   = 12'h777;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bin",  32'(bin),  32'd0);
        check("abort_err",  32'(err),  32'd0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        convert("w058", 12'h058, 10'd58, 1'b0);

        // Random valid words
        for (int i = 0; i < 500; i++) begin
            v = int'($urandom_range(0, 999));
            w = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            convert("rand_valid", w, 10'(v), 1'b0);
        end

        // Random words containing at least one invalid digit
        for (int i = 0; i < 40; i++) begin
            w = 12'($urandom);
            w[4*(i % 3) +: 4] = 4'(10 + (i % 6));
            convert("rand_invalid", w, ref_bin(w), ref_err(w));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
